nand_xfer_ctrl: RTL and testbench

Parametrised NAND-flash transfer controller: the next generation of the team's flash/memory copy engine. It accepts one command at a time over a valid/ready handshake and performs one of four operations between an on-chip single-port memory and a NAND flash device: page read, page program, block erase, or status read. Program and erase automatically finish with a status poll. A busy timeout aborts any operation whose flash stays busy too long.

---
 rtl/nand_xfer_ctrl.sv | 160 ++++++++++++++++
 tb/tb_nand_xfer_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/nand_xfer_ctrl.sv
// nand_xfer_ctrl: one-command-at-a-time transfer engine between on-chip memory and NAND flash
module nand_xfer_ctrl #(
   parameter int DW       = 8,
   parameter int MAW      = 7,
   parameter int COLW     = 9,
   parameter int ROWW     = 17,
   parameter int RB_DLY   = 2,
   parameter int BUSY_TMO = 4096
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [COLW-1:0] cmd_col,
   input  logic [ROWW-1:0] cmd_row,
   input  logic [MAW-1:0]  cmd_maddr,
   input  logic [MAW-1:0]  cmd_len,
   output logic            done,
   output logic            err,
   output logic            tmo,
   output logic [DW-1:0]   sts,
   output logic            M_RW,
   output logic [MAW-1:0]  M_A,
   inout  wire  [DW-1:0]   M_D,
   inout  wire  [DW-1:0]   F_IO,
   output logic            F_CLE,
   output logic            F_ALE,
   output logic            F_WEN,
   output logic            F_REN,
   input  logic            F_RB
);
   localparam int RCYC = (ROWW + DW - 1) / DW;
   localparam int RPW  = RCYC * DW;
   localparam int BCW  = $clog2(RB_DLY + BUSY_TMO + 1);
   localparam logic [1:0] OP_PROG  = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_ERASE = 2'b10;
   localparam logic [1:0] OP_STAT  = 2'b11;

   typedef enum logic [3:0] {IDLE, CMD, ADDR, WDATA, RDATA, CONF, BUSY, STAT, FIN} state_t;

   state_t         state, state_d;
   logic           ph, sub, tmo_q;
   logic [MAW-1:0] cnt, ridx;
   logic [BCW-1:0] bc;
   logic [1:0]     op;
   logic [COLW-1:0] col;
   logic [ROWW-1:0] row;
   logic [RPW-1:0] row_pad;
   logic [MAW-1:0] maddr, len;
   logic [DW-1:0]  wreg, rreg, sts_q, fio, abyte, col_byte, ptr;
   logic           byte_st, wr_st, rd_st, last_addr, poll, tmo_hit;

   assign byte_st   = state inside {CMD, ADDR, WDATA, RDATA, CONF, STAT};
   assign wr_st     = state inside {CMD, ADDR, WDATA, CONF} || (state == STAT && !sub);
   assign rd_st     = state == RDATA || (state == STAT && sub);
   assign last_addr = cnt == MAW'(op == OP_ERASE ? RCYC - 1 : RCYC);
   assign poll      = bc >= BCW'(RB_DLY);
   assign tmo_hit   = poll && !F_RB && bc == BCW'(RB_DLY + BUSY_TMO - 1);
   assign row_pad   = RPW'(row);
   assign ridx      = op == OP_ERASE ? cnt : cnt - 1'b1;
   assign col_byte  = DW'(col[COLW-2:0]);
   assign ptr       = {{(DW-1){1'b0}}, col[COLW-1]};
   assign abyte     = (op != OP_ERASE && cnt == '0) ? col_byte : DW'(row_pad >> (ridx * DW));

   // byte placed on F_IO for whichever write-type byte cycle is in progress
   always_comb begin
      fio = state == CMD   ? (op == OP_ERASE ? DW'(8'h60) : sub ? DW'(8'h80) : ptr) :
            state == ADDR  ? abyte :
            state == WDATA ? wreg :
            state == CONF  ? (op == OP_ERASE ? DW'(8'hD0) : DW'(8'h10)) :
                             DW'(8'h70);
   end

   assign cmd_ready = state == IDLE;
   assign done      = state == FIN;
   assign tmo       = done & tmo_q;
   assign err       = done & (tmo_q | (~op[0] & sts_q[0]));
   assign sts       = sts_q;
   assign F_CLE     = state inside {CMD, CONF} || (state == STAT && !sub);
   assign F_ALE     = state == ADDR;
   assign F_WEN     = !(wr_st && !ph);
   assign F_REN     = !(rd_st && !ph);
   assign M_RW      = !(state == RDATA && ph);
   assign M_A       = state == WDATA ? maddr + cnt + MAW'(1) :
                      state == RDATA ? maddr + cnt :
                      state == ADDR  ? maddr : '0;
   assign M_D       = M_RW ? {DW{1'bz}} : rreg;
   assign F_IO      = wr_st ? fio : {DW{1'bz}};

   // state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_d;

   // next-state: each byte phase advances on its second cycle
   always_comb begin
      state_d = state;
      case (state)
         IDLE:  if (cmd_valid) state_d = cmd_op == OP_STAT ? STAT : CMD;
         CMD:   if (ph && !(op == OP_PROG && !sub)) state_d = ADDR;
         ADDR:  if (ph && last_addr) state_d = op == OP_READ ? BUSY : op == OP_PROG ? WDATA : CONF;
         WDATA: if (ph && cnt == len) state_d = CONF;
         CONF:  if (ph) state_d = BUSY;
         BUSY:  if (poll && F_RB) state_d = op == OP_READ ? RDATA : STAT;
                else if (tmo_hit) state_d = FIN;
         RDATA: if (ph && cnt == len) state_d = FIN;
         STAT:  if (ph && sub) state_d = FIN;
         FIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // byte phase, sub-step, byte index and busy counters restart on every state change
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         ph  <= 1'b0;
         sub <= 1'b0;
         cnt <= '0;
         bc  <= '0;
      end else if (state_d != state) begin
         ph  <= 1'b0;
         sub <= 1'b0;
         cnt <= '0;
         bc  <= '0;
      end else begin
         ph  <= byte_st & ~ph;
         sub <= sub | (ph & (state == CMD | state == STAT));
         cnt <= cnt + MAW'(ph & (state inside {ADDR, WDATA, RDATA}));
         bc  <= bc + BCW'(state == BUSY);
      end

   // command latch plus data, status and timeout capture
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         op    <= '0;
         col   <= '0;
         row   <= '0;
         maddr <= '0;
         len   <= '0;
         wreg  <= '0;
         rreg  <= '0;
         sts_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         if (cmd_valid && cmd_ready) begin
            op    <= cmd_op;
            col   <= cmd_col;
            row   <= cmd_row;
            maddr <= cmd_maddr;
            len   <= cmd_len;
            tmo_q <= 1'b0;
         end
         if (state == BUSY && tmo_hit) tmo_q <= 1'b1;
         if (ph && state inside {ADDR, WDATA}) wreg <= M_D;
         if (!ph && state == RDATA) rreg <= F_IO;
         if (!ph && sub && state == STAT) sts_q <= F_IO;
      end
endmodule

// File: tb/tb_nand_xfer_ctrl.sv
// tb_nand_xfer_ctrl: directed checks of nand_xfer_ctrl against a flash/memory model
module tb_nand_xfer_ctrl;
   logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, F_RB = 1'b1;
   logic [1:0]  cmd_op = '0;
   logic [8:0]  cmd_col = '0;
   logic [16:0] cmd_row = '0;
   logic [6:0]  cmd_maddr = '0, cmd_len = '0;
   logic        cmd_ready, done, err, tmo, M_RW, F_CLE, F_ALE, F_WEN, F_REN;
   logic [7:0]  sts;
   logic [6:0]  M_A;
   wire  [7:0]  M_D, F_IO;
   logic [7:0]  mem [0:127];
   logic [7:0]  fdat [0:255];
   logic [7:0]  fidx = '0;
   logic [9:0]  wlog [0:1023];
   int          wptr = 0, nwr = 0, both = 0;
   logic        pre_we = 1'b0;
   logic [6:0]  pre_a = '0;
   logic [7:0]  pre_d = '0;
   int          n_cmp = 0, n_bad = 0;
   int          wb, nb, cyc;
   logic [7:0]  fb;
   logic [9:0]  q[$];

   nand_xfer_ctrl dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_col(cmd_col), .cmd_row(cmd_row), .cmd_maddr(cmd_maddr), .cmd_len(cmd_len),
      .done(done), .err(err), .tmo(tmo), .sts(sts), .M_RW(M_RW), .M_A(M_A), .M_D(M_D),
      .F_IO(F_IO), .F_CLE(F_CLE), .F_ALE(F_ALE), .F_WEN(F_WEN), .F_REN(F_REN), .F_RB(F_RB)
   );

   always #5 clk = ~clk;

   assign M_D  = M_RW ? mem[M_A] : 8'bz;
   assign F_IO = F_REN ? 8'bz : fdat[fidx];

   // memory writes, bench preloads, and flash read pointer advance
   always @(posedge clk) begin
      if (!M_RW) begin
         mem[M_A] <= M_D;
         nwr <= nwr + 1;
      end else if (pre_we) mem[pre_a] <= pre_d;
      if (!F_REN) fidx <= fidx + 8'd1;
   end

   // log every byte written to flash as {CLE, ALE, IO}
   always @(negedge clk) begin
      if (!F_WEN) begin
         wlog[wptr[9:0]] <= {F_CLE, F_ALE, F_IO};
         wptr <= wptr + 1;
      end
      if (F_CLE && F_ALE) both <= both + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [8:0] col, input logic [16:0] row,
                        input logic [6:0] ma, input logic [6:0] ln);
      @(negedge clk);
      cmd_op = op; cmd_col = col; cmd_row = row; cmd_maddr = ma; cmd_len = ln; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0; cmd_op = ~op; cmd_col = ~col; cmd_row = ~row; cmd_maddr = ~ma; cmd_len = ~ln;
   endtask

   task automatic run(output int c);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!done && c < 6000);
   endtask

   task automatic mw(input logic [6:0] a, input logic [7:0] d);
      @(negedge clk);
      pre_a = a; pre_d = d; pre_we = 1'b1;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic check_log(input string tag, input int base, input logic [9:0] e[$]);
      chk({tag, "_nbytes"}, 32'(wptr - base), 32'(e.size()));
      foreach (e[i]) chk($sformatf("%s_b%0d", tag, i), 32'(wlog[base + i]), 32'(e[i]));
   endtask

   task automatic mark;
      wb = wptr; nb = nwr; fb = fidx;
   endtask

   initial begin
      #1 rst = 1'b0;
      #2;
      chk("rst_ready", 32'(cmd_ready), 1);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_tmo", 32'(tmo), 0);
      chk("rst_sts", 32'(sts), 0);
      chk("rst_mrw", 32'(M_RW), 1);
      chk("rst_ma", 32'(M_A), 0);
      chk("rst_ctl", 32'({F_CLE, F_ALE, F_WEN, F_REN}), 32'h3);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      mark();
      fdat[fb] = 8'h11; fdat[8'(fb + 1)] = 8'h22; fdat[8'(fb + 2)] = 8'h33; fdat[8'(fb + 3)] = 8'h44;
      issue(2'b01, 9'h105, 17'h000A3, 7'h7E, 7'd3);
      run(cyc);
      chk("rd_done", 32'(done), 1);
      chk("rd_cyc", 32'(cyc), 22);
      chk("rd_err", 32'(err), 0);
      chk("rd_tmo", 32'(tmo), 0);
      chk("rd_ready_in_fin", 32'(cmd_ready), 0);
      chk("rd_nwr", 32'(nwr - nb), 4);
      chk("rd_m7e", 32'(mem[7'h7E]), 32'h11);
      chk("rd_m7f", 32'(mem[7'h7F]), 32'h22);
      chk("rd_m00", 32'(mem[7'h00]), 32'h33);
      chk("rd_m01", 32'(mem[7'h01]), 32'h44);
      q = '{10'h201, 10'h105, 10'h1A3, 10'h100, 10'h100};
      check_log("rd_log", wb, q);
      @(negedge clk);
      chk("rd_ready_after", 32'(cmd_ready), 1);
      chk("rd_done_pulse", 32'(done), 0);

      mw(7'h0, 8'hAA);
      mw(7'h1, 8'h55);
      mark();
      fdat[fb] = 8'hE0;
      issue(2'b00, 9'h010, 17'h1, 7'h0, 7'd1);
      run(cyc);
      chk("pg_done", 32'(done), 1);
      chk("pg_cyc", 32'(cyc), 26);
      chk("pg_sts", 32'(sts), 32'hE0);
      chk("pg_err", 32'(err), 0);
      chk("pg_nwr", 32'(nwr - nb), 0);
      q = '{10'h200, 10'h280, 10'h110, 10'h101, 10'h100, 10'h100, 10'h0AA, 10'h055, 10'h210, 10'h270};
      check_log("pg_log", wb, q);

      mark();
      fdat[fb] = 8'hE1;
      issue(2'b10, 9'h000, 17'h1FFFF, 7'h0, 7'd0);
      run(cyc);
      chk("er_done", 32'(done), 1);
      chk("er_cyc", 32'(cyc), 18);
      chk("er_err", 32'(err), 1);
      chk("er_tmo", 32'(tmo), 0);
      chk("er_sts", 32'(sts), 32'hE1);
      q = '{10'h260, 10'h1FF, 10'h1FF, 10'h101, 10'h2D0, 10'h270};
      check_log("er_log", wb, q);

      mark();
      fdat[fb] = 8'h5B;
      issue(2'b11, 9'h0, 17'h0, 7'h0, 7'd0);
      run(cyc);
      chk("st_cyc", 32'(cyc), 5);
      chk("st_sts", 32'(sts), 32'h5B);
      chk("st_err", 32'(err), 0);
      q = '{10'h270};
      check_log("st_log", wb, q);

      F_RB = 1'b0;
      mark();
      issue(2'b01, 9'h0, 17'h0, 7'h10, 7'd0);
      run(cyc);
      chk("to_done", 32'(done), 1);
      chk("to_cyc", 32'(cyc), 10 + 2 + 4096 + 1);
      chk("to_tmo", 32'(tmo), 1);
      chk("to_err", 32'(err), 1);
      chk("to_nwr", 32'(nwr - nb), 0);
      chk("to_nrd", 32'(fidx - fb), 0);
      chk("to_sts_hold", 32'(sts), 32'h5B);
      F_RB = 1'b1;

      mark();
      for (int k = 0; k < 128; k++) fdat[8'(fb + k)] = 8'(k) ^ 8'h5A;
      issue(2'b01, 9'h0, 17'h0, 7'h05, 7'd127);
      run(cyc);
      chk("wr_cyc", 32'(cyc), 270);
      chk("wr_nwr", 32'(nwr - nb), 128);
      chk("wr_m05", 32'(mem[7'h05]), 32'h5A);
      chk("wr_m7f", 32'(mem[7'h7F]), 32'h20);
      chk("wr_m04", 32'(mem[7'h04]), 32'h25);
      chk("wr_err", 32'(err), 0);

      mw(7'h0, 8'h69);
      mw(7'h1, 8'h96);
      issue(2'b00, 9'h0, 17'h5, 7'h0, 7'd7);
      repeat (15) @(negedge clk);
      chk("rs_mid_wen", 32'(F_WEN), 0);
      chk("rs_mid_io", 32'(F_IO), 32'h96);
      chk("rs_mid_ready", 32'(cmd_ready), 0);
      rst = 1'b0;
      #1;
      chk("rs_ready", 32'(cmd_ready), 1);
      chk("rs_done", 32'({done, err, tmo}), 0);
      chk("rs_sts", 32'(sts), 0);
      chk("rs_mrw", 32'(M_RW), 1);
      chk("rs_ma", 32'(M_A), 0);
      chk("rs_ctl", 32'({F_CLE, F_ALE, F_WEN, F_REN}), 32'h3);
      @(negedge clk);
      rst = 1'b1;

      mark();
      fdat[fb] = 8'hC3; fdat[8'(fb + 1)] = 8'h3C;
      issue(2'b01, 9'h000, 17'h2, 7'h40, 7'd1);
      run(cyc);
      chk("ar_cyc", 32'(cyc), 18);
      chk("ar_m40", 32'(mem[7'h40]), 32'hC3);
      chk("ar_m41", 32'(mem[7'h41]), 32'h3C);
      chk("ar_err", 32'(err), 0);
      q = '{10'h200, 10'h100, 10'h102, 10'h100, 10'h100};
      check_log("ar_log", wb, q);

      chk("cle_ale_excl", 32'(both), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
